// File: rtl/core_ctrl_if.sv
// core_ctrl_if: control/instruction bundle between the core_ctrl sequencer and its host/core.
// master = sequencer side, slave = host/core side.
interface core_ctrl_if;
  logic        start;
  logic        abort;
  logic [16:0] inst;
  logic        busy;
  logic        done;
  logic        rd_valid;
  logic [3:0]  rd_add;

  modport master (
    input  start,
    input  abort,
    output inst,
    output busy,
    output done,
    output rd_valid,
    output rd_add
  );

  modport slave (
    output start,
    output abort,
    input  inst,
    input  busy,
    input  done,
    input  rd_valid,
    input  rd_add
  );
endinterface

// File: rtl/core_ctrl.sv
// core_ctrl: fixed-schedule instruction sequencer for core (K load, Q execute, output FIFO drain to pmem).
// Define CORE_CTRL_READBACK_EN to add the pmem readback phase that drives rd_valid/rd_add.
module core_ctrl #(
  parameter int total_cycle = 8,
  parameter int col         = 8,
  parameter int load_gap    = 10,
  parameter int drain_gap   = 10
) (
  input  logic        clk,
  input  logic        reset,
  core_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_KLOAD = 4'd1,
    ST_KTAIL = 4'd2,
    ST_KGAP  = 4'd3,
    ST_EXEC  = 4'd4,
    ST_EGAP  = 4'd5,
    ST_MOVE  = 4'd6,
    ST_RDBK  = 4'd7,
    ST_DONE  = 4'd8
  } state_t;

  localparam int B_OFIFO_RD = 16;
  localparam int B_EXECUTE  = 7;
  localparam int B_LOAD     = 6;
  localparam int B_QMEM_RD  = 5;
  localparam int B_KMEM_RD  = 3;
  localparam int B_PMEM_RD  = 1;
  localparam int B_PMEM_WR  = 0;

  localparam logic [7:0] COL_M1   = 8'(col - 1);
  localparam logic [7:0] TC_M1    = 8'(total_cycle - 1);
  localparam logic [7:0] LGAP_M1  = 8'(load_gap - 1);
  localparam logic [7:0] DGAP_M1  = 8'(drain_gap - 1);
  localparam logic       HAS_LGAP = (load_gap > 0) ? 1'b1 : 1'b0;
  localparam logic       HAS_DGAP = (drain_gap > 0) ? 1'b1 : 1'b0;

  state_t      state_r;
  state_t      state_s;
  logic [7:0]  cnt_r;
  logic [7:0]  cnt_s;
  logic [3:0]  addr_r;
  logic [3:0]  addr_s;
  logic        last_s;

  logic [16:0] inst_r;
  logic [16:0] inst_s;
  logic        busy_r;
  logic        busy_s;
  logic        done_r;
  logic        done_s;
  logic        rd_valid_r;
  logic        rd_valid_s;
  logic [3:0]  rd_add_r;
  logic [3:0]  rd_add_s;

  // Next state: the shared down-counter and the address counter restart on every state entry.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r - 8'd1;
    addr_s  = addr_r + 4'd1;
    last_s  = (cnt_r == 8'd0);
    if (bus.abort) begin
      state_s = ST_IDLE;
      cnt_s   = 8'd0;
      addr_s  = 4'd0;
    end else if (state_r == ST_IDLE) begin
      addr_s = 4'd0;
      if (bus.start) begin
        state_s = ST_KLOAD;
        cnt_s   = COL_M1;
      end else begin
        cnt_s = 8'd0;
      end
    end else if (last_s) begin
      addr_s = 4'd0;
      case (state_r)
        ST_KLOAD: begin
          state_s = ST_KTAIL;
          cnt_s   = 8'd0;
        end
        ST_KTAIL: begin
          if (HAS_LGAP) begin
            state_s = ST_KGAP;
            cnt_s   = LGAP_M1;
          end else begin
            state_s = ST_EXEC;
            cnt_s   = TC_M1;
          end
        end
        ST_KGAP: begin
          state_s = ST_EXEC;
          cnt_s   = TC_M1;
        end
        ST_EXEC: begin
          if (HAS_DGAP) begin
            state_s = ST_EGAP;
            cnt_s   = DGAP_M1;
          end else begin
            state_s = ST_MOVE;
            cnt_s   = TC_M1;
          end
        end
        ST_EGAP: begin
          state_s = ST_MOVE;
          cnt_s   = TC_M1;
        end
`ifdef CORE_CTRL_READBACK_EN
        ST_MOVE: begin
          state_s = ST_RDBK;
          cnt_s   = TC_M1;
        end
        ST_RDBK: begin
          state_s = ST_DONE;
          cnt_s   = 8'd0;
        end
`else
        ST_MOVE: begin
          state_s = ST_DONE;
          cnt_s   = 8'd0;
        end
`endif
        default: begin
          state_s = ST_IDLE;
          cnt_s   = 8'd0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Output decode from the upcoming state so inst/busy/done line up with state_r after the edge.
  always_comb begin
    inst_s = 17'd0;
    busy_s = (state_s != ST_IDLE);
    done_s = 1'b0;
    case (state_s)
      ST_KLOAD: begin
        inst_s[B_LOAD]    = 1'b1;
        inst_s[B_KMEM_RD] = 1'b1;
        inst_s[15:12]     = addr_s;
      end
      ST_KTAIL: begin
        inst_s[B_LOAD] = 1'b1;
      end
      ST_EXEC: begin
        inst_s[B_EXECUTE] = 1'b1;
        inst_s[B_QMEM_RD] = 1'b1;
        inst_s[15:12]     = addr_s;
      end
      ST_MOVE: begin
        inst_s[B_OFIFO_RD] = 1'b1;
        inst_s[B_PMEM_WR]  = 1'b1;
        inst_s[11:8]       = addr_s;
      end
`ifdef CORE_CTRL_READBACK_EN
      ST_RDBK: begin
        inst_s[B_PMEM_RD] = 1'b1;
        inst_s[11:8]      = addr_s;
      end
`endif
      ST_DONE: begin
        done_s = 1'b1;
      end
      default: begin
        inst_s = 17'd0;
      end
    endcase
  end

  // Readback tracking: pmem data arrives one cycle after the read issued in RDBK.
  always_comb begin
`ifdef CORE_CTRL_READBACK_EN
    if ((state_r == ST_RDBK) && !bus.abort) begin
      rd_valid_s = 1'b1;
      rd_add_s   = addr_r;
    end else begin
      rd_valid_s = 1'b0;
      rd_add_s   = 4'd0;
    end
`else
    rd_valid_s = 1'b0;
    rd_add_s   = 4'd0;
`endif
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 8'd0;
      addr_r     <= 4'd0;
      inst_r     <= 17'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      rd_valid_r <= 1'b0;
      rd_add_r   <= 4'd0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      addr_r     <= addr_s;
      inst_r     <= inst_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      rd_valid_r <= rd_valid_s;
      rd_add_r   <= rd_add_s;
    end
  end

  assign bus.inst     = inst_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.rd_valid = rd_valid_r;
  assign bus.rd_add   = rd_add_r;

endmodule

// File: tb/tb_core_ctrl.sv
// tb_core_ctrl: table-driven check of the core_ctrl schedule, plus hand sequences for
// zero-gap timing and asynchronous reset.
module tb_core_ctrl;
  localparam int TC   = 8;
  localparam int COLN = 8;
  localparam int LG   = 10;
  localparam int DG   = 10;
`ifdef CORE_CTRL_READBACK_EN
  localparam int GAP0_LEN = COLN + 1 + TC + TC + TC + 1;
`else
  localparam int GAP0_LEN = COLN + 1 + TC + TC + 1;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  core_ctrl_if bus();
  core_ctrl_if bus0();

  core_ctrl #(.total_cycle(TC), .col(COLN), .load_gap(LG), .drain_gap(DG)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  core_ctrl #(.total_cycle(TC), .col(COLN), .load_gap(0), .drain_gap(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0));

  typedef struct {
    logic        start;
    logic        abort;
    logic [16:0] inst;
    logic        busy;
    logic        done;
    logic        rd_valid;
    logic [3:0]  rd_add;
  } vec_t;

  vec_t vq[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(logic s, logic a, logic [16:0] i, logic b, logic d);
    vec_t v;
    v.start = s; v.abort = a; v.inst = i; v.busy = b; v.done = d;
    v.rd_valid = 1'b0; v.rd_add = 4'd0;
    vq.push_back(v);
  endtask

  task automatic seg(int n, logic [16:0] base, int shift);
    for (int k = 0; k < n; k++) begin
      if (shift > 0) push(1'b0, 1'b0, base | (17'(k) << shift), 1'b1, 1'b0);
      else           push(1'b0, 1'b0, base, 1'b1, 1'b0);
    end
  endtask

  // One complete schedule starting with the start row, truncated to limit rows.
  task automatic add_sched(int limit);
    int first = vq.size();
    seg(COLN, 17'h00048, 12);  // load + kmem_rd
    seg(1, 17'h00040, 0);      // load only
    seg(LG, 17'h00000, 0);
    seg(TC, 17'h000A0, 12);    // execute + qmem_rd
    seg(DG, 17'h00000, 0);
    seg(TC, 17'h10001, 8);     // ofifo_rd + pmem_wr
`ifdef CORE_CTRL_READBACK_EN
    begin
      int rb = vq.size();
      seg(TC, 17'h00002, 8);   // pmem_rd
      push(1'b0, 1'b0, 17'h0, 1'b1, 1'b1);
      for (int k = 1; k <= TC; k++) begin
        vq[rb + k].rd_valid = 1'b1;
        vq[rb + k].rd_add   = 4'(k - 1);
      end
    end
`else
    push(1'b0, 1'b0, 17'h0, 1'b1, 1'b1);
`endif
    vq[first].start = 1'b1;
    while (vq.size() > first + limit) void'(vq.pop_back());
  endtask

  initial begin
    int base;
    int done_at;
    logic [16:0] hist [64];

    reset = 1'b1;
    bus.start = 1'b0;  bus.abort = 1'b0;
    bus0.start = 1'b0; bus0.abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 32'({bus.inst, bus.busy, bus.done, bus.rd_valid, bus.rd_add}), 32'd0);
    reset = 1'b0;

    push(1'b0, 1'b0, 17'h0, 1'b0, 1'b0);
    push(1'b0, 1'b0, 17'h0, 1'b0, 1'b0);
    push(1'b1, 1'b1, 17'h0, 1'b0, 1'b0);   // start+abort in IDLE stays idle
    push(1'b0, 1'b0, 17'h0, 1'b0, 1'b0);
    base = vq.size();
    add_sched(1000);
    vq[base + COLN + 1 + LG + TC + DG + 3].start = 1'b1;   // re-pulse during MOVE
    push(1'b0, 1'b0, 17'h0, 1'b0, 1'b0);
    add_sched(COLN + 1 + LG + 3);                        // up to the 3rd EXEC cycle
    push(1'b0, 1'b1, 17'h0, 1'b0, 1'b0);                 // abort
    repeat (3) push(1'b0, 1'b0, 17'h0, 1'b0, 1'b0);
    add_sched(1000);
    repeat (2) push(1'b0, 1'b0, 17'h0, 1'b0, 1'b0);

    for (int i = 0; i < vq.size(); i++) begin
      bus.start = vq[i].start;
      bus.abort = vq[i].abort;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i),
          32'({bus.inst, bus.busy, bus.done, bus.rd_valid, bus.rd_add}),
          32'({vq[i].inst, vq[i].busy, vq[i].done, vq[i].rd_valid, vq[i].rd_add}));
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;

    // Zero-gap instance: back-to-back phases and overall length.
    done_at = -1;
    for (int c = 0; c < 64; c++) hist[c] = 17'h0;
    bus0.start = 1'b1;
    @(posedge clk);
    #1;
    bus0.start = 1'b0;
    for (int c = 0; c < 64; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      hist[c] = bus0.inst;
      if (bus0.done && done_at < 0) done_at = c;
      if (done_at >= 0) break;
    end
    chk("gap0_ktail", 32'(hist[COLN]), 32'h00040);
    chk("gap0_exec_first", 32'(hist[COLN + 1]), 32'h000A0);
    chk("gap0_exec_last", 32'(hist[COLN + TC]), 32'h070A0);
    chk("gap0_move_first", 32'(hist[COLN + TC + 1]), 32'h10001);
    chk("gap0_done_len", 32'(done_at + 1), 32'(GAP0_LEN));
    @(posedge clk);
    #1;
    chk("gap0_busy_after_done", 32'(bus0.busy), 32'd0);

    // Asynchronous reset mid-KLOAD.
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    chk("kload_pre_reset", 32'(bus.inst), 32'h01048);
    #3;
    reset = 1'b1;
    #1;
    chk("async_reset_inst", 32'(bus.inst), 32'd0);
    chk("async_reset_busy", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("post_reset_idle", 32'({bus.inst, bus.busy}), 32'd0);
    end
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("restart_first", 32'({bus.inst, bus.busy}), 32'({17'h00048, 1'b1}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
